// File: rtl/radix4_sdf_stage.sv
// Radix-4 decimation-in-frequency SDF stage: a 3*STRIDE-deep delay line feeds one
// full radix-4 butterfly per accepted sample during the last quarter of each block.
module radix4_sdf_stage #(
    parameter int DATA_W = 32,
    parameter int STRIDE = 4,
    parameter int IDX_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic                     in_sof,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [IDX_W-1:0]         out_idx,
    output logic signed [DATA_W+1:0] out0_re,
    output logic signed [DATA_W+1:0] out0_im,
    output logic signed [DATA_W+1:0] out1_re,
    output logic signed [DATA_W+1:0] out1_im,
    output logic signed [DATA_W+1:0] out2_re,
    output logic signed [DATA_W+1:0] out2_im,
    output logic signed [DATA_W+1:0] out3_re,
    output logic signed [DATA_W+1:0] out3_im
);

    localparam int OUT_W = DATA_W + 2;
    localparam int BLOCK = 4 * STRIDE;
    localparam int DEPTH = 3 * STRIDE;
    localparam int CNT_W = $clog2(BLOCK);
    localparam logic [CNT_W-1:0] LAST_E = CNT_W'(BLOCK - 1);
    localparam logic [CNT_W-1:0] Q3_E   = CNT_W'(DEPTH);

    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         eff_idx;
    logic                     in_q3;
    logic signed [DATA_W-1:0] line_re [DEPTH];
    logic signed [DATA_W-1:0] line_im [DEPTH];

    // A fresh in_sof forces this sample to index 0 regardless of the running count.
    assign eff_idx = in_sof ? '0 : cnt;
    assign in_q3   = (eff_idx >= Q3_E);

    function automatic logic signed [OUT_W-1:0] sext(input logic signed [DATA_W-1:0] x);
        return {{2{x[DATA_W-1]}}, x};
    endfunction

    logic signed [OUT_W-1:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;
    logic signed [OUT_W-1:0] ac_sum_re, ac_sum_im, ac_dif_re, ac_dif_im;
    logic signed [OUT_W-1:0] bd_sum_re, bd_sum_im, bd_dif_re, bd_dif_im;

    // Taps sit at L-1, 2L-1 and 3L-1: the samples accepted L, 2L and 3L ago.
    assign a_re = sext(line_re[DEPTH-1]);
    assign a_im = sext(line_im[DEPTH-1]);
    assign b_re = sext(line_re[2*STRIDE-1]);
    assign b_im = sext(line_im[2*STRIDE-1]);
    assign c_re = sext(line_re[STRIDE-1]);
    assign c_im = sext(line_im[STRIDE-1]);
    assign d_re = sext(in_re);
    assign d_im = sext(in_im);

    assign ac_sum_re = a_re + c_re;
    assign ac_sum_im = a_im + c_im;
    assign ac_dif_re = a_re - c_re;
    assign ac_dif_im = a_im - c_im;
    assign bd_sum_re = b_re + d_re;
    assign bd_sum_im = b_im + d_im;
    assign bd_dif_re = b_re - d_re;
    assign bd_dif_im = b_im - d_im;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out0_re   <= '0;
            out0_im   <= '0;
            out1_re   <= '0;
            out1_im   <= '0;
            out2_re   <= '0;
            out2_im   <= '0;
            out3_re   <= '0;
            out3_im   <= '0;
            // NOTE: the delay line is cleared too, so an abandoned block leaves no stale taps.
            for (int i = 0; i < DEPTH; i++) begin
                line_re[i] <= '0;
                line_im[i] <= '0;
            end
        end else if (in_valid) begin
            line_re[0] <= in_re;
            line_im[0] <= in_im;
            for (int i = 1; i < DEPTH; i++) begin
                line_re[i] <= line_re[i-1];
                line_im[i] <= line_im[i-1];
            end
            cnt       <= (eff_idx == LAST_E) ? '0 : eff_idx + CNT_W'(1);
            out_valid <= in_q3;
            if (in_q3) begin
                out_idx  <= IDX_W'(eff_idx - Q3_E);
                out_last <= (eff_idx == LAST_E);
                out0_re  <= ac_sum_re + bd_sum_re;
                out0_im  <= ac_sum_im + bd_sum_im;
                out1_re  <= ac_dif_re + bd_dif_im;
                out1_im  <= ac_dif_im - bd_dif_re;
                out2_re  <= ac_sum_re - bd_sum_re;
                out2_im  <= ac_sum_im - bd_sum_im;
                out3_re  <= ac_dif_re - bd_dif_im;
                out3_im  <= ac_dif_im + bd_dif_re;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_radix4_sdf_stage.sv
// Scoreboard bench for radix4_sdf_stage: a STRIDE=4 and a STRIDE=1 instance,
// expected butterflies queued at drive time and popped when out_valid appears.
module tb_radix4_sdf_stage;

    localparam int DW = 32;
    localparam int OW = DW + 2;
    localparam logic [OW-1:0] FS_X0 = 34'h200000000;

    typedef struct packed {
        logic [1:0]    idx;
        logic          last;
        logic [OW-1:0] r0, i0, r1, i1, r2, i2, r3, i3;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                 v4, sof4, v1, sof1;
    logic signed [DW-1:0] re4, im4, re1, im1;
    logic                 o_valid4, o_last4, o_valid1, o_last1;
    logic [1:0]           o_idx4;
    logic [0:0]           o_idx1;
    logic signed [OW-1:0] a0r, a0i, a1r, a1i, a2r, a2i, a3r, a3i;
    logic signed [OW-1:0] b0r, b0i, b1r, b1i, b2r, b2i, b3r, b3i;

    radix4_sdf_stage #(.DATA_W(DW), .STRIDE(4), .IDX_W(2)) dut4 (
        .clk(clk), .reset(reset), .in_valid(v4), .in_sof(sof4), .in_re(re4), .in_im(im4),
        .out_valid(o_valid4), .out_last(o_last4), .out_idx(o_idx4),
        .out0_re(a0r), .out0_im(a0i), .out1_re(a1r), .out1_im(a1i),
        .out2_re(a2r), .out2_im(a2i), .out3_re(a3r), .out3_im(a3i)
    );

    radix4_sdf_stage #(.DATA_W(DW), .STRIDE(1), .IDX_W(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_sof(sof1), .in_re(re1), .in_im(im1),
        .out_valid(o_valid1), .out_last(o_last1), .out_idx(o_idx1),
        .out0_re(b0r), .out0_im(b0i), .out1_re(b1r), .out1_im(b1i),
        .out2_re(b2r), .out2_im(b2i), .out3_re(b3r), .out3_im(b3i)
    );

    exp_t q4[$];
    exp_t q1[$];
    int   passed = 0;
    int   total  = 0;
    bit   prev_valid4 = 1'b0;
    bit   consec4 = 1'b0;
    int   blk_re[16];
    int   blk_im[16];

    function automatic exp_t model(input int k, input bit last,
                                   input longint ar, input longint ai, input longint br, input longint bi,
                                   input longint cr, input longint ci, input longint dr, input longint di);
        exp_t e;
        e.idx  = 2'(k);
        e.last = last;
        e.r0 = OW'(ar + br + cr + dr);
        e.i0 = OW'(ai + bi + ci + di);
        e.r1 = OW'((ar - cr) + (bi - di));
        e.i1 = OW'((ai - ci) - (br - dr));
        e.r2 = OW'((ar + cr) - (br + dr));
        e.i2 = OW'((ai + ci) - (bi + di));
        e.r3 = OW'((ar - cr) - (bi - di));
        e.i3 = OW'((ai - ci) + (br - dr));
        return e;
    endfunction

    // One clock: inputs are applied before the edge, outputs sampled on the falling edge.
    task automatic tick();
        exp_t act, exp;
        @(posedge clk);
        @(negedge clk);
        if (o_valid4) begin
            if (prev_valid4) consec4 = 1'b1;
            total++;
            act = '{o_idx4, o_last4, a0r, a0i, a1r, a1i, a2r, a2i, a3r, a3i};
            if (q4.size() == 0) begin
                $display("FAIL bfly4_unexpected: got out_valid=1 idx=%0d, required no output", o_idx4);
            end else begin
                exp = q4.pop_front();
                if (act !== exp) $display("FAIL bfly4 k=%0d: got %h required %h", exp.idx, act, exp);
                else passed++;
            end
        end
        prev_valid4 = o_valid4;
        if (o_valid1) begin
            total++;
            act = '{{1'b0, o_idx1}, o_last1, b0r, b0i, b1r, b1i, b2r, b2i, b3r, b3i};
            if (q1.size() == 0) begin
                $display("FAIL bfly1_unexpected: got out_valid=1, required no output");
            end else begin
                exp = q1.pop_front();
                if (act !== exp) $display("FAIL bfly1: got %h required %h", act, exp);
                else passed++;
            end
        end
    endtask

    task automatic fill_ramp();
        for (int n = 0; n < 16; n++) begin
            blk_re[n] = n;
            blk_im[n] = n;
        end
    endtask

    task automatic fill_random();
        for (int n = 0; n < 16; n++) begin
            blk_re[n] = int'($urandom);
            blk_im[n] = int'($urandom);
        end
    endtask

    task automatic push_ramp();
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.idx  = 2'(k);
            e.last = (k == 3);
            e.r0 = OW'(4 * k + 24);
            e.i0 = OW'(4 * k + 24);
            e.r1 = OW'(-16);
            e.i1 = '0;
            e.r2 = OW'(-8);
            e.i2 = OW'(-8);
            e.r3 = '0;
            e.i3 = OW'(-16);
            q4.push_back(e);
        end
    endtask

    task automatic send_block4(input bit use_sof, input bit gap, input bit push);
        if (push) begin
            for (int k = 0; k < 4; k++)
                q4.push_back(model(k, k == 3, blk_re[k], blk_im[k], blk_re[4+k], blk_im[4+k],
                                   blk_re[8+k], blk_im[8+k], blk_re[12+k], blk_im[12+k]));
        end
        for (int n = 0; n < 16; n++) begin
            v4 = 1'b1; sof4 = use_sof && (n == 0); re4 = blk_re[n]; im4 = blk_im[n];
            tick();
            if (gap) begin
                // Idle cycle with in_sof high: must be ignored without in_valid.
                v4 = 1'b0; sof4 = 1'b1; re4 = int'($urandom); im4 = int'($urandom);
                tick();
            end
        end
        v4 = 1'b0; sof4 = 1'b0;
    endtask

    task automatic check_drained(input string name);
        repeat (3) tick();
        total++;
        if (q4.size() != 0 || q1.size() != 0)
            $display("FAIL %s_drain: got %0d/%0d pending results, required 0/0", name, q4.size(), q1.size());
        else passed++;
    endtask

    task automatic check_cleared(input string name);
        total++;
        if (o_valid4 !== 1'b0 || o_valid1 !== 1'b0)
            $display("FAIL %s_valid: got %b/%b, required 0/0", name, o_valid4, o_valid1);
        else passed++;
        total++;
        if ({o_last4, o_idx4, a0r, a0i, a1r, a1i, a2r, a2i, a3r, a3i} !== '0)
            $display("FAIL %s_data4: got %h, required 0", name, {a0r, a0i, a1r, a1i, a2r, a2i, a3r, a3i});
        else passed++;
        total++;
        if ({o_last1, o_idx1, b0r, b0i, b1r, b1i, b2r, b2i, b3r, b3i} !== '0)
            $display("FAIL %s_data1: got %h, required 0", name, {b0r, b0i, b1r, b1i, b2r, b2i, b3r, b3i});
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        v4 = 1'b1; sof4 = 1'b1; re4 = 7; im4 = 7;
        v1 = 1'b1; sof1 = 1'b1; re1 = 7; im1 = 7;
        tick();
        tick();
        check_cleared("reset");
        v4 = 1'b0; sof4 = 1'b0; v1 = 1'b0; sof1 = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_ramp();
        fill_ramp();
        push_ramp();
        send_block4(1'b1, 1'b0, 1'b0);
        check_drained("ramp");
    endtask

    task automatic test_gapped();
        fill_ramp();
        push_ramp();
        consec4 = 1'b0;
        send_block4(1'b1, 1'b1, 1'b0);
        check_drained("gapped");
        total++;
        if (consec4) $display("FAIL gapped_consecutive: got back-to-back out_valid, required isolated pulses");
        else passed++;
    endtask

    task automatic test_full_scale();
        exp_t e;
        for (int n = 0; n < 16; n++) begin
            blk_re[n] = int'(32'h8000_0000);
            blk_im[n] = int'(32'h8000_0000);
        end
        for (int k = 0; k < 4; k++) begin
            e = '0;
            e.idx = 2'(k);
            e.last = (k == 3);
            e.r0 = FS_X0;
            e.i0 = FS_X0;
            q4.push_back(e);
        end
        send_block4(1'b1, 1'b0, 1'b0);
        check_drained("full_scale");
    endtask

    task automatic test_reset_mid();
        fill_ramp();
        push_ramp();
        // Only k=0 and k=1 of this block complete before reset lands.
        q4 = q4[0:1];
        for (int n = 0; n < 14; n++) begin
            v4 = 1'b1; sof4 = (n == 0); re4 = n; im4 = n;
            tick();
        end
        reset = 1'b0;
        v4 = 1'b1; sof4 = 1'b0; re4 = 99; im4 = 99;
        tick();
        check_cleared("reset_mid");
        tick();
        reset = 1'b1;
        v4 = 1'b0;
        tick();
        total++;
        if (o_valid4 !== 1'b0) $display("FAIL reset_mid_release: got out_valid=%b, required 0", o_valid4);
        else passed++;
        fill_random();
        send_block4(1'b1, 1'b0, 1'b1);
        check_drained("reset_mid");
    endtask

    task automatic test_sof_realign();
        for (int n = 0; n < 6; n++) begin
            v4 = 1'b1; sof4 = (n == 0); re4 = int'($urandom); im4 = int'($urandom);
            tick();
        end
        fill_random();
        send_block4(1'b1, 1'b0, 1'b1);
        check_drained("sof_realign");
    endtask

    task automatic test_back_to_back();
        fill_random();
        send_block4(1'b1, 1'b0, 1'b1);
        fill_random();
        send_block4(1'b0, 1'b0, 1'b1);
        check_drained("back_to_back");
    endtask

    task automatic test_stride1();
        exp_t e;
        int   s_re[4];
        int   s_im[4];
        e.idx = 2'd0; e.last = 1'b1;
        e.r0 = OW'(10); e.i0 = '0;
        e.r1 = OW'(-2); e.i1 = OW'(2);
        e.r2 = OW'(-2); e.i2 = '0;
        e.r3 = OW'(-2); e.i3 = OW'(-2);
        q1.push_back(e);
        for (int n = 0; n < 4; n++) begin
            v1 = 1'b1; sof1 = (n == 0); re1 = n + 1; im1 = 0;
            tick();
        end
        for (int n = 0; n < 4; n++) begin
            s_re[n] = int'($urandom);
            s_im[n] = int'($urandom);
        end
        q1.push_back(model(0, 1'b1, s_re[0], s_im[0], s_re[1], s_im[1], s_re[2], s_im[2], s_re[3], s_im[3]));
        for (int n = 0; n < 4; n++) begin
            v1 = 1'b1; sof1 = 1'b0; re1 = s_re[n]; im1 = s_im[n];
            tick();
        end
        v1 = 1'b0;
        check_drained("stride1");
    endtask

    initial begin
        reset = 1'b0;
        v4 = 1'b0; sof4 = 1'b0; re4 = '0; im4 = '0;
        v1 = 1'b0; sof1 = 1'b0; re1 = '0; im1 = '0;
        test_reset();
        test_ramp();
        test_gapped();
        test_full_scale();
        test_reset_mid();
        test_sof_realign();
        test_back_to_back();
        test_stride1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/radix4_sdf_stage.md
Name: radix4_sdf_stage

Overview:
- Parametrised radix-4 decimation-in-frequency stage for the streaming FFT. It replaces the fixed signal-select plus first-butterfly pair.
- Accepts one complex sample per valid cycle into a 3*STRIDE-deep delay line and tracks position in a 4*STRIDE-sample block.
- During the last quarter of each block it computes one full radix-4 butterfly per accepted sample and emits all four complex results in parallel.
- Chains into later stages, with STRIDE = 4 for the 16-point first stage and STRIDE = 1 for the last stage.

Parameters:
DATA_W  32  signed width of each real/imag input component
STRIDE  4   tap spacing L; block length 4*L; any integer >= 1
IDX_W   2   width of out_idx; must satisfy 2^IDX_W >= STRIDE (use 1 when STRIDE = 1)

Ports:
clk      in   1         rising-edge clock
reset    in   1         synchronous, active-low reset
in_valid in   1         input sample present this cycle
in_sof   in   1         qualifies in_valid: this sample is index 0 of a block
in_re    in   DATA_W    signed real part of input sample
in_im    in   DATA_W    signed imaginary part of input sample
out_valid out 1         butterfly results valid this cycle
out_last out  1         high with out_valid on the final butterfly of a block (k = L-1)
out_idx  out  IDX_W     butterfly index k, 0..L-1
out0_re, out0_im, out1_re, out1_im, out2_re, out2_im, out3_re, out3_im  out  DATA_W+2 each  signed X0..X3

Behaviour:
- Reset (reset == 0 at a rising edge):
  - sample counter cnt <= 0; all delay-line entries <= 0.
  - out_valid, out_last, out_idx and all outX_* <= 0.
  - Reset overrides in_valid in the same cycle.
  - A block in progress is abandoned; no output occurs until a new block completes its last quarter.
- Acceptance:
  - A sample is accepted on any rising edge with reset == 1 and in_valid == 1.
  - When in_valid == 0, the delay line and cnt hold, out_valid <= 0, and data outputs hold their last value.
- Delay line:
  - Taps D1, D2, D3 hold the samples accepted 1L, 2L and 3L acceptances earlier (stage i = i*L deep in total).
  - It shifts only on acceptance.
- Counter:
  - Effective index e = 0 if in_sof == 1, else cnt.
  - On acceptance, cnt <= (e == 4L-1) ? 0 : e+1.
  - in_sof asserted mid-block realigns the block immediately; the prior partial block is discarded and does not emit its remaining butterflies.
  - in_sof without in_valid is ignored.
- Butterfly, computed on acceptance when e >= 3L, with k = e - 3L:
  - Operands: a = D3, b = D2, c = D1, d = the current input sample.
  - X0 = a+b+c+d
  - X1 = (a-c) - j(b-d), i.e. re = (a-c).re + (b-d).im, im = (a-c).im - (b-d).re
  - X2 = (a+c) - (b+d)
  - X3 = (a-c) + j(b-d), i.e. re = (a-c).re - (b-d).im, im = (a-c).im + (b-d).re
  - All operands are sign-extended to DATA_W+2 before arithmetic; this is exact with no wrap or saturation.
- Output timing:
  - Results, out_idx = k and out_last = (k == L-1) are registered on the accepting edge.
  - out_valid = 1 for exactly the cycle after, so latency is 1 cycle from accepting d.
  - When e < 3L, the accepting edge drives out_valid <= 0 and the outputs hold.
- Throughput: one butterfly per accepted sample in the last quarter, so L butterflies per block.
- Back-to-back blocks need no idle cycle; after cnt wraps, the next sample is index 0 even without in_sof.

Test Plan:
- STRIDE=4, in_sof with sample 0, then re = im = n for n = 0..15 on consecutive cycles. Required response, with out_valid high on the 4 cycles after samples 12..15:
  - k = 0..3;
  - X0 = (4k+24) + j(4k+24);
  - X1 = -16 + j0;
  - X2 = -8 - j8;
  - X3 = 0 - j16;
  - out_last only at k = 3.
- Same stream with in_valid = 0 on every other cycle -> identical results and order; out_valid never high on two consecutive cycles.
- Full-scale inputs: all a..d = -2^(DATA_W-1) (real and imag) -> X0 = -2^(DATA_W+1) in both parts, no wrap; X1 = X2 = X3 = 0.
- Reset driven low after sample 13 of a block, then released -> out_valid stays 0 and the next in_sof block produces correct values with no stale tap contamination.
- in_sof reasserted at sample 6 of a block -> that sample is treated as index 0; the first out_valid follows the 12th sample after it.
- STRIDE=1, samples 1, 2, 3, 4 (im = 0) -> one output: X0 = 10, X1 = -2 + j2, X2 = -2, X3 = -2 - j2; out_idx = 0, out_last = 1.
